// File: rtl/xbus_disp32_pkg.sv
// Shared definitions for the 8051 XDATA display register block:
// register offsets, control bit positions and bus FSM encoding.
package xbus_disp32_pkg;

   localparam logic [2:0]  OFF_STAGE0 = 3'd0;
   localparam logic [2:0]  OFF_STAGE1 = 3'd1;
   localparam logic [2:0]  OFF_STAGE2 = 3'd2;
   localparam logic [2:0]  OFF_STAGE3 = 3'd3;
   localparam logic [2:0]  OFF_CTRL   = 3'd4;
   localparam logic [2:0]  OFF_COMMIT = 3'd5;
   localparam logic [15:0] NUM_REGS   = 16'd6;

   localparam int CTRL_OE_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WR_ACT = 2'd1,
      ST_RD_ACT = 2'd2
   } bus_state_e;

endpackage

// File: rtl/xbus_disp32_regs_strobe_sync.sv
// Brings an asynchronous active-low bus strobe into CLK and flags its edges.
// Flops reset to 1 so a strobe held low through reset reads as a fresh fall.
module strobe_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic nRST,
   input  logic strb_n,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;
   logic                   rise_r;
   logic                   fall_r;

   // Synchroniser chain plus registered edge pulses
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         sync_r <= {SYNC_STAGES{1'b1}};
         prev_r <= 1'b1;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], strb_n};
         prev_r <= sync_r[SYNC_STAGES-1];
         rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
         fall_r <= ~sync_r[SYNC_STAGES-1] & prev_r;
      end
   end

   assign level = sync_r[SYNC_STAGES-1];
   assign rise  = rise_r;
   assign fall  = fall_r;

endmodule

// File: rtl/xbus_disp32_regs.sv
// 8051 XDATA register file for the 32-bit hex display: byte staging with an
// atomic commit to disp_data, a control register for disp_oe, and read-back.
module xbus_disp32_regs
   import xbus_disp32_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR   = 16'hF000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [15:0] ADDR,
   input  logic [7:0]  DIN,
   input  logic        nWR,
   input  logic        nRD,
   output logic [7:0]  DOUT,
   output logic        DOUT_EN,
   output logic [31:0] disp_data,
   output logic        disp_oe
);

   bus_state_e  state_r;
   logic [15:0] addr_cap_r;
   logic [7:0]  din_cap_r;
   logic [31:0] stage_r;
   logic [31:0] disp_data_r;
   logic        disp_oe_r;
   logic [7:0]  dout_r;
   logic        dout_en_r;

   logic        wr_level_s, wr_rise_s, wr_fall_s;
   logic        rd_level_s, rd_rise_s, rd_fall_s;
   logic [15:0] off_full_s;
   logic [2:0]  off_s;
   logic        hit_s;
   logic [7:0]  rd_data_s;

   strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
      .CLK    (CLK),
      .nRST   (nRST),
      .strb_n (nWR),
      .level  (wr_level_s),
      .rise   (wr_rise_s),
      .fall   (wr_fall_s)
   );

   strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
      .CLK    (CLK),
      .nRST   (nRST),
      .strb_n (nRD),
      .level  (rd_level_s),
      .rise   (rd_rise_s),
      .fall   (rd_fall_s)
   );

   // Address decode and read-back mux from the captured address
   always_comb begin
      off_full_s = addr_cap_r - BASE_ADDR;
      off_s      = off_full_s[2:0];
      if (off_full_s < NUM_REGS) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
      rd_data_s = 8'h00;
      case (off_s)
         OFF_STAGE0: rd_data_s = disp_data_r[7:0];
         OFF_STAGE1: rd_data_s = disp_data_r[15:8];
         OFF_STAGE2: rd_data_s = disp_data_r[23:16];
         OFF_STAGE3: rd_data_s = disp_data_r[31:24];
         OFF_CTRL:   rd_data_s[CTRL_OE_BIT] = disp_oe_r;
         default:    rd_data_s = 8'h00;
      endcase
   end

   // Bus FSM with staging, commit and read-back registers
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_r     <= ST_IDLE;
         addr_cap_r  <= 16'h0000;
         din_cap_r   <= 8'h00;
         stage_r     <= 32'h0000_0000;
         disp_data_r <= 32'h0000_0000;
         disp_oe_r   <= 1'b0;
         dout_r      <= 8'h00;
         dout_en_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // Acting on a fall only while the level is still low rejects glitches
               if (wr_fall_s && !wr_level_s) begin
                  state_r    <= ST_WR_ACT;
                  addr_cap_r <= ADDR;
                  din_cap_r  <= DIN;
               end else if (rd_fall_s && !rd_level_s) begin
                  state_r    <= ST_RD_ACT;
                  addr_cap_r <= ADDR;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WR_ACT: begin
               if (wr_rise_s) begin
                  if (hit_s) begin
                     case (off_s)
                        OFF_STAGE0: stage_r[7:0]   <= din_cap_r;
                        OFF_STAGE1: stage_r[15:8]  <= din_cap_r;
                        OFF_STAGE2: stage_r[23:16] <= din_cap_r;
                        OFF_STAGE3: begin
                           stage_r[31:24] <= din_cap_r;
                           disp_data_r    <= {din_cap_r, stage_r[23:0]};
                        end
                        OFF_CTRL:   disp_oe_r   <= din_cap_r[CTRL_OE_BIT];
                        OFF_COMMIT: disp_data_r <= stage_r;
                        default:    stage_r     <= stage_r;
                     endcase
                  end
                  state_r <= ST_IDLE;
               end else begin
                  addr_cap_r <= ADDR;
                  din_cap_r  <= DIN;
               end
            end
            ST_RD_ACT: begin
               if (rd_rise_s) begin
                  dout_en_r <= 1'b0;
                  dout_r    <= 8'h00;
                  state_r   <= ST_IDLE;
               end else begin
                  addr_cap_r <= ADDR;
                  dout_en_r  <= hit_s;
                  dout_r     <= hit_s ? rd_data_s : 8'h00;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               dout_en_r <= 1'b0;
            end
         endcase
      end
   end

   assign DOUT      = dout_r;
   assign DOUT_EN   = dout_en_r;
   assign disp_data = disp_data_r;
   assign disp_oe   = disp_oe_r;

endmodule

// File: tb/tb_xbus_disp32_regs.sv
// Directed bench for xbus_disp32_regs: a vector table of bus writes/reads plus
// hand sequences for reset, strobe priority and reset during a write.
module tb_xbus_disp32_regs;

   localparam logic [15:0] BASE = 16'hF000;

   logic        CLK;
   logic        nRST;
   logic [15:0] ADDR;
   logic [7:0]  DIN;
   logic        nWR;
   logic        nRD;
   logic [7:0]  DOUT;
   logic        DOUT_EN;
   logic [31:0] disp_data;
   logic        disp_oe;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cur_disp;
   logic        cur_oe;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  data;
      logic [31:0] exp_disp;
      logic        exp_oe;
      logic        exp_en;
      logic [7:0]  exp_dout;
   } vec_t;

   vec_t vecs[19];

   xbus_disp32_regs #(.BASE_ADDR(16'hF000), .SYNC_STAGES(2)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .ADDR      (ADDR),
      .DIN       (DIN),
      .nWR       (nWR),
      .nRD       (nRD),
      .DOUT      (DOUT),
      .DOUT_EN   (DOUT_EN),
      .disp_data (disp_data),
      .disp_oe   (disp_oe)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic vec_t mk(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                               input logic [31:0] exp_disp, input logic exp_oe,
                               input logic exp_en, input logic [7:0] exp_dout);
      vec_t v;
      v.wr = wr; v.addr = addr; v.data = data; v.exp_disp = exp_disp;
      v.exp_oe = exp_oe; v.exp_en = exp_en; v.exp_dout = exp_dout;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Write with latency check: old values through 3 cycles after nWR rises, new at cycle 4
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d,
                            input logic [31:0] exp_disp, input logic exp_oe);
      ADDR = a; DIN = d; nWR = 1'b0;
      repeat (8) tick();
      nWR = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k < 4) begin
            check("wr_hold_disp", disp_data, cur_disp);
            check("wr_hold_oe", {31'd0, disp_oe}, {31'd0, cur_oe});
         end
      end
      check("wr_disp", disp_data, exp_disp);
      check("wr_oe", {31'd0, disp_oe}, {31'd0, exp_oe});
      repeat (4) tick();
      cur_disp = exp_disp;
      cur_oe   = exp_oe;
   endtask

   task automatic bus_read(input logic [15:0] a, input logic exp_en, input logic [7:0] exp_dout);
      logic seen;
      seen = 1'b0;
      ADDR = a; nRD = 1'b0;
      repeat (8) begin
         tick();
         seen = seen | DOUT_EN;
      end
      check("rd_en", {31'd0, DOUT_EN}, {31'd0, exp_en});
      check("rd_en_seen", {31'd0, seen}, {31'd0, exp_en});
      if (exp_en) check("rd_dout", {24'd0, DOUT}, {24'd0, exp_dout});
      nRD = 1'b1;
      repeat (6) tick();
      check("rd_en_release", {31'd0, DOUT_EN}, 32'd0);
      check("rd_disp", disp_data, cur_disp);
   endtask

   initial begin
      logic seen;

      vecs[0]  = mk(1'b1, BASE + 16'd0, 8'h78, 32'h0000_0000, 1'b1, 1'b0, 8'h00);
      vecs[1]  = mk(1'b1, BASE + 16'd1, 8'h56, 32'h0000_0000, 1'b1, 1'b0, 8'h00);
      vecs[2]  = mk(1'b1, BASE + 16'd2, 8'h34, 32'h0000_0000, 1'b1, 1'b0, 8'h00);
      vecs[3]  = mk(1'b1, BASE + 16'd3, 8'h12, 32'h1234_5678, 1'b1, 1'b0, 8'h00);
      vecs[4]  = mk(1'b1, BASE + 16'd0, 8'hAB, 32'h1234_5678, 1'b1, 1'b0, 8'h00);
      vecs[5]  = mk(1'b1, BASE + 16'd5, 8'h00, 32'h1234_56AB, 1'b1, 1'b0, 8'h00);
      vecs[6]  = mk(1'b1, BASE + 16'd4, 8'h00, 32'h1234_56AB, 1'b0, 1'b0, 8'h00);
      vecs[7]  = mk(1'b1, BASE + 16'd4, 8'hFF, 32'h1234_56AB, 1'b1, 1'b0, 8'h00);
      vecs[8]  = mk(1'b1, BASE + 16'd2, 8'h99, 32'h1234_56AB, 1'b1, 1'b0, 8'h00);
      vecs[9]  = mk(1'b0, BASE + 16'd4, 8'h00, 32'h1234_56AB, 1'b1, 1'b1, 8'h01);
      vecs[10] = mk(1'b0, BASE + 16'd2, 8'h00, 32'h1234_56AB, 1'b1, 1'b1, 8'h34);
      vecs[11] = mk(1'b0, BASE + 16'd0, 8'h00, 32'h1234_56AB, 1'b1, 1'b1, 8'hAB);
      vecs[12] = mk(1'b0, BASE + 16'd3, 8'h00, 32'h1234_56AB, 1'b1, 1'b1, 8'h12);
      vecs[13] = mk(1'b0, BASE + 16'd5, 8'h00, 32'h1234_56AB, 1'b1, 1'b1, 8'h00);
      vecs[14] = mk(1'b1, BASE + 16'd6, 8'h55, 32'h1234_56AB, 1'b1, 1'b0, 8'h00);
      vecs[15] = mk(1'b1, 16'hEFFF,     8'h55, 32'h1234_56AB, 1'b1, 1'b0, 8'h00);
      vecs[16] = mk(1'b0, BASE + 16'd6, 8'h00, 32'h1234_56AB, 1'b1, 1'b0, 8'h00);
      vecs[17] = mk(1'b0, 16'hEFFF,     8'h00, 32'h1234_56AB, 1'b1, 1'b0, 8'h00);
      vecs[18] = mk(1'b1, BASE + 16'd5, 8'h00, 32'h1299_56AB, 1'b1, 1'b0, 8'h00);

      // Reset held with nWR low; the write must start once reset releases
      nRST = 1'b0; nWR = 1'b0; nRD = 1'b1; ADDR = BASE + 16'd4; DIN = 8'h01;
      repeat (3) tick();
      check("rst_disp", disp_data, 32'h0);
      check("rst_oe", {31'd0, disp_oe}, 32'd0);
      check("rst_en", {31'd0, DOUT_EN}, 32'd0);
      check("rst_dout", {24'd0, DOUT}, 32'd0);
      nRST = 1'b1;
      repeat (8) tick();
      nWR = 1'b1;
      repeat (6) tick();
      check("rst_release_wr_oe", {31'd0, disp_oe}, 32'd1);
      check("rst_release_wr_disp", disp_data, 32'h0);
      cur_disp = 32'h0;
      cur_oe   = 1'b1;

      for (int i = 0; i < 19; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data, vecs[i].exp_disp, vecs[i].exp_oe);
         else            bus_read(vecs[i].addr, vecs[i].exp_en, vecs[i].exp_dout);
      end

      // Both strobes fall together: write wins, held-low nRD must not start a read
      seen = 1'b0;
      ADDR = BASE + 16'd4; DIN = 8'h00; nWR = 1'b0; nRD = 1'b0;
      repeat (8) begin tick(); seen = seen | DOUT_EN; end
      nWR = 1'b1;
      repeat (10) begin tick(); seen = seen | DOUT_EN; end
      check("prio_wr_oe", {31'd0, disp_oe}, 32'd0);
      check("prio_no_rd", {31'd0, seen}, 32'd0);
      nRD = 1'b1;
      repeat (6) tick();
      check("prio_en_idle", {31'd0, DOUT_EN}, 32'd0);
      cur_oe = 1'b0;
      bus_read(BASE + 16'd4, 1'b1, 8'h00);

      // Reset in the middle of a commit write; strobe released while in reset
      ADDR = BASE + 16'd3; DIN = 8'h77; nWR = 1'b0;
      repeat (6) tick();
      nRST = 1'b0;
      tick();
      nWR = 1'b1;
      repeat (2) tick();
      nRST = 1'b1;
      repeat (10) tick();
      check("midrst_disp", disp_data, 32'h0);
      check("midrst_oe", {31'd0, disp_oe}, 32'd0);
      check("midrst_en", {31'd0, DOUT_EN}, 32'd0);
      cur_disp = 32'h0;
      cur_oe   = 1'b0;
      bus_write(BASE + 16'd5, 8'h00, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
